// File: rtl/bip_control.sv
// Instruction-sequencing control unit for the BIP accumulator processor: PC, fetch, decode, datapath strobes.
// Optional executed-cycle counter is built only when BIP_CYCLE_COUNT_EN is defined.
module bip_control #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [PC_WIDTH-1:0]    prog_addr,
  output logic [PC_WIDTH-1:0]    operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   op_sub,
  output logic                   wr_acc,
  output logic                   wr_ram,
  output logic                   rd_ram,
  output logic                   halted,
  output logic [31:0]            cycle_count,
  output logic [1:0]             fsm_state
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [4:0]          opcode;

  assign opcode    = prog_data[INSTR_WIDTH-1 -: 5];
  assign prog_addr = pc;
  assign fsm_state = state;
  assign halted    = (state == ST_HALT);

  // Strobes depend only on registered state and the fetched word, never on rst,
  // so a reset edge clears them in the following cycle.
  always_comb begin
    operand = '0;
    sel_a   = SEL_A_RAM;
    sel_b   = 1'b0;
    op_sub  = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    if (state == ST_EXEC) begin
      operand = prog_data[PC_WIDTH-1:0];
      case (opcode)
        OP_STO: wr_ram = 1'b1;
        OP_LD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SEL_A_RAM;
        end
        OP_LDI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_IMM;
        end
        OP_ADD, OP_SUB: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b0;
          op_sub = (opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b1;
          op_sub = (opcode == OP_SUBI);
        end
        default: ;
      endcase
    end
  end

  // HLT leaves PC pointing at itself; every other opcode (including NOPs) advances it.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
          pc_next    = pc + PC_WIDTH'(1);
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state != ST_HALT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_count = cycle_cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: per-cycle scoreboard against a spec-level model,
// plus directed checks of the documented program scenarios.
module tb_bip_control;

  localparam int SB_W = 64;
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
`ifdef BIP_CYCLE_COUNT_EN
  localparam logic [31:0] HALT_COUNT = 32'd8;
`else
  localparam logic [31:0] HALT_COUNT = 32'd0;
`endif

  // strobe vector order: {sel_a[1:0], sel_b, op_sub, wr_acc, wr_ram, rd_ram}
  localparam logic [6:0] STB_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] STB_STO  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] STB_LD   = 7'b00_0_0_1_0_1;
  localparam logic [6:0] STB_LDI  = 7'b01_0_0_1_0_0;
  localparam logic [6:0] STB_ADD  = 7'b10_0_0_1_0_1;
  localparam logic [6:0] STB_ADDI = 7'b10_1_0_1_0_0;
  localparam logic [6:0] STB_SUB  = 7'b10_0_1_1_0_1;
  localparam logic [6:0] STB_SUBI = 7'b10_1_1_1_0_0;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] prog_data = 16'h0000;
  logic [10:0] prog_addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        op_sub;
  logic        wr_acc;
  logic        wr_ram;
  logic        rd_ram;
  logic        halted;
  logic [31:0] cycle_count;
  logic [1:0]  fsm_state;
  logic [6:0]  strobes;

  assign strobes = {sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram};

  bip_control dut (
    .clk         (clk),
    .rst         (rst),
    .prog_data   (prog_data),
    .prog_addr   (prog_addr),
    .operand     (operand),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .op_sub      (op_sub),
    .wr_acc      (wr_acc),
    .wr_ram      (wr_ram),
    .rd_ram      (rd_ram),
    .halted      (halted),
    .cycle_count (cycle_count),
    .fsm_state   (fsm_state)
  );

  // synchronous-read program memory, one cycle latency
  logic [15:0] mem [0:2047];
  always @(posedge clk) prog_data <= mem[prog_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model, advanced at the same edge as the DUT
  logic [1:0]  m_state = ST_FETCH;
  logic [10:0] m_pc    = '0;
  logic [31:0] m_cnt   = '0;
  logic [SB_W-1:0] exp_q [$];

  function automatic logic [6:0] expected_strobes(input logic [4:0] op);
    case (op)
      5'd1:    return STB_STO;
      5'd2:    return STB_LD;
      5'd3:    return STB_LDI;
      5'd4:    return STB_ADD;
      5'd5:    return STB_ADDI;
      5'd6:    return STB_SUB;
      5'd7:    return STB_SUBI;
      default: return STB_NONE;
    endcase
  endfunction

  function automatic logic [SB_W-1:0] expected_word(input logic [1:0] st, input logic [10:0] pc,
                                                    input logic [31:0] cnt);
    logic [15:0] word;
    logic [10:0] opnd;
    logic [6:0]  stb;
    word = mem[pc];
    opnd = '0;
    stb  = STB_NONE;
    if (st == ST_EXEC) begin
      opnd = word[10:0];
      stb  = expected_strobes(word[15:11]);
    end
`ifdef BIP_CYCLE_COUNT_EN
    return {st, pc, opnd, stb, (st == ST_HALT), cnt};
`else
    return {st, pc, opnd, stb, (st == ST_HALT), 32'd0 & cnt};
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = ST_FETCH;
      m_pc    = '0;
      m_cnt   = '0;
    end else begin
      if (m_state != ST_HALT) m_cnt = m_cnt + 32'd1;
      case (m_state)
        ST_FETCH: m_state = ST_EXEC;
        ST_EXEC: begin
          if (mem[m_pc][15:11] == 5'd0) begin
            m_state = ST_HALT;
          end else begin
            m_state = ST_FETCH;
            m_pc    = m_pc + 11'd1;
          end
        end
        default: m_state = ST_HALT;
      endcase
    end
    exp_q.push_back(expected_word(m_state, m_pc, m_cnt));
  end

  // scoreboard: pop one expected word per cycle and compare away from the active edge
  logic [SB_W-1:0] sb_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      check("sb_state",   64'(fsm_state),   64'(sb_exp[63:62]));
      check("sb_addr",    64'(prog_addr),   64'(sb_exp[61:51]));
      check("sb_operand", 64'(operand),     64'(sb_exp[50:40]));
      check("sb_strobes", 64'(strobes),     64'(sb_exp[39:33]));
      check("sb_halted",  64'(halted),      64'(sb_exp[32]));
      check("sb_count",   64'(cycle_count), 64'(sb_exp[31:0]));
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // on return the DUT is in cycle 0 (first FETCH) with rst low
  task automatic release_reset;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_nop;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h4000;
  endtask

  task automatic load_prog1;
    fill_nop();
    mem[0] = 16'h1805;
    mem[1] = 16'h2803;
    mem[2] = 16'h0807;
    mem[3] = 16'h0000;
  endtask

  task automatic load_prog2;
    fill_nop();
    mem[0] = 16'h1002;
    mem[1] = 16'h3002;
    mem[2] = 16'h3801;
    mem[3] = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_prog1();

    // program 1: LDI 5, ADDI 3, STO 7, HLT
    hold_reset();
    release_reset();
    check("rst_state",   64'(fsm_state),   64'(ST_FETCH));
    check("rst_addr",    64'(prog_addr),   64'd0);
    check("rst_operand", 64'(operand),     64'd0);
    check("rst_strobes", 64'(strobes),     64'(STB_NONE));
    check("rst_halted",  64'(halted),      64'd0);
    check("rst_count",   64'(cycle_count), 64'd0);
    wait_cycles(1);
    check("ldi_strobes", 64'(strobes), 64'(STB_LDI));
    check("ldi_operand", 64'(operand), 64'd5);
    wait_cycles(1);
    check("fetch_no_strobes", 64'(strobes), 64'(STB_NONE));
    wait_cycles(1);
    check("addi_strobes", 64'(strobes), 64'(STB_ADDI));
    check("addi_operand", 64'(operand), 64'd3);
    wait_cycles(2);
    check("sto_strobes", 64'(strobes), 64'(STB_STO));
    check("sto_operand", 64'(operand), 64'd7);
    wait_cycles(2);
    check("hlt_exec_strobes", 64'(strobes), 64'(STB_NONE));
    check("hlt_exec_halted",  64'(halted),  64'd0);
    wait_cycles(1);
    check("halt_halted", 64'(halted),      64'd1);
    check("halt_addr",   64'(prog_addr),   64'd3);
    check("halt_count",  64'(cycle_count), 64'(HALT_COUNT));
    wait_cycles(20);
    check("halt_hold_halted", 64'(halted),      64'd1);
    check("halt_hold_addr",   64'(prog_addr),   64'd3);
    check("halt_hold_count",  64'(cycle_count), 64'(HALT_COUNT));
    check("halt_hold_stb",    64'(strobes),     64'(STB_NONE));

    // program 2: LD 2, SUB 2, SUBI 1, HLT
    hold_reset();
    load_prog2();
    release_reset();
    wait_cycles(1);
    check("ld_strobes", 64'(strobes), 64'(STB_LD));
    check("ld_operand", 64'(operand), 64'd2);
    wait_cycles(2);
    check("sub_strobes", 64'(strobes), 64'(STB_SUB));
    wait_cycles(2);
    check("subi_strobes", 64'(strobes), 64'(STB_SUBI));
    check("subi_operand", 64'(operand), 64'd1);
    wait_cycles(3);
    check("p2_halted", 64'(halted), 64'd1);

    // 0xF800 NOP at 0, then NOPs everywhere: PC wraps 2047 -> 0 without halting
    hold_reset();
    fill_nop();
    mem[0] = 16'hF800;
    release_reset();
    wait_cycles(1);
    check("nop_strobes", 64'(strobes), 64'(STB_NONE));
    check("nop_operand", 64'(operand), 64'd0);
    wait_cycles(1);
    check("nop_next_addr", 64'(prog_addr), 64'd1);
    wait_cycles(4092);
    check("wrap_addr_top",  64'(prog_addr), 64'd2047);
    check("wrap_state_top", 64'(fsm_state), 64'(ST_FETCH));
    wait_cycles(2);
    check("wrap_addr_zero", 64'(prog_addr), 64'd0);
    check("wrap_no_halt",   64'(halted),    64'd0);
`ifdef BIP_CYCLE_COUNT_EN
    check("wrap_count", 64'(cycle_count), 64'd4096);
`else
    check("wrap_count", 64'(cycle_count), 64'd0);
`endif

    // reset during EXEC of ADDI, then reset out of HALT
    hold_reset();
    load_prog1();
    release_reset();
    wait_cycles(3);
    check("pre_rst_addi", 64'(strobes), 64'(STB_ADDI));
    rst = 1'b1;
    wait_cycles(1);
    check("mid_rst_strobes", 64'(strobes),     64'(STB_NONE));
    check("mid_rst_addr",    64'(prog_addr),   64'd0);
    check("mid_rst_state",   64'(fsm_state),   64'(ST_FETCH));
    check("mid_rst_count",   64'(cycle_count), 64'd0);
    rst = 1'b0;
    wait_cycles(8);
    check("rerun_halted", 64'(halted), 64'd1);
    rst = 1'b1;
    wait_cycles(1);
    check("halt_rst_halted", 64'(halted),    64'd0);
    check("halt_rst_addr",   64'(prog_addr), 64'd0);
    rst = 1'b0;
    wait_cycles(1);
    check("restart_ldi", 64'(strobes), 64'(STB_LDI));
    wait_cycles(1);
    check("restart_addr", 64'(prog_addr), 64'd1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
